// File: rtl/rf_arb_pkg.sv
// Shared widths and the queued write entry type for the register write arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package rf_arb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_entry_t;
endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Writeback / long-latency / scoreboard / register-array signal bundle for reg_wr_arbiter.
// Latency: n/a (wires only).
// Backpressure: lu_ready from the arbiter throttles lu_valid.
interface reg_wr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] chk_addr_a;
  logic [ADDR_W-1:0] chk_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              stall_req;
  logic              rf_enable;
  logic [ADDR_W-1:0] rf_addr_w;
  logic [DATA_W-1:0] rf_data_w;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           iss_valid, iss_addr, chk_addr_a, chk_addr_b,
    input  lu_ready, hazard_a, hazard_b, stall_req,
           rf_enable, rf_addr_w, rf_data_w, fifo_count
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
           iss_valid, iss_addr, chk_addr_a, chk_addr_b,
    output lu_ready, hazard_a, hazard_b, stall_req,
           rf_enable, rf_addr_w, rf_data_w, fifo_count
  );
endinterface

// File: rtl/rf_arb_fifo.sv
// Circular buffer holding long-latency results until a free write slot.
// Latency: push visible at head the next cycle; head is a combinational read.
// Backpressure: caller must not push when count==DEPTH nor pop when empty.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  rf_wr_entry_t               push_dat,
  input  logic                       pop,
  output rf_wr_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_wr_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares the register-array write port: writeback wins, long-latency results drain from a FIFO.
// Latency: wb written same cycle; queued result written >=1 cycle after push. Macro RF_ARB_STARVE_EN adds stall_req.
// Backpressure: lu_ready = FIFO not full (registered state only); stall_req asks the pipeline for a bubble.
module reg_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5
) (
  input  logic           clock,
  input  logic           reset,
  reg_wr_arbiter_if.slave bus
);
  import rf_arb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 1 << ADDR_W;

  rf_wr_entry_t     push_dat;
  rf_wr_entry_t     head;
  logic             push;
  logic             pop;
  logic             wb_req;
  logic             fifo_nonempty;
  logic [CNT_W-1:0] count;
  logic [NREG-1:0]  busy;

  assign wb_req        = bus.wb_valid && (bus.wb_addr != ZERO_REG);
  assign fifo_nonempty = (count != '0);
  assign bus.lu_ready  = (count < CNT_W'(DEPTH));
  assign push          = bus.lu_valid && bus.lu_ready;
  assign push_dat      = '{addr: bus.lu_addr, data: bus.lu_data};
  assign bus.fifo_count = count;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  always_comb begin
    pop           = 1'b0;
    bus.rf_enable = 1'b0;
    bus.rf_addr_w = ZERO_REG;
    bus.rf_data_w = {DATA_W{1'b0}};
    if (wb_req) begin
      bus.rf_enable = 1'b1;
      bus.rf_addr_w = bus.wb_addr;
      bus.rf_data_w = bus.wb_data;
    end else if (fifo_nonempty) begin
      // A head entry for $0 still pops; it just never reaches the array.
      pop           = 1'b1;
      bus.rf_enable = (head.addr != ZERO_REG);
      bus.rf_addr_w = head.addr;
      bus.rf_data_w = head.data;
    end
    if (reset) bus.rf_enable = 1'b0;
  end

  // Issue is applied after the pop clear so a same-address set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (pop) busy[head.addr] <= 1'b0;
      if (bus.iss_valid && (bus.iss_addr != ZERO_REG)) busy[bus.iss_addr] <= 1'b1;
    end
  end

  assign bus.hazard_a = (bus.chk_addr_a != ZERO_REG) && busy[bus.chk_addr_a];
  assign bus.hazard_b = (bus.chk_addr_b != ZERO_REG) && busy[bus.chk_addr_b];

`ifdef RF_ARB_STARVE_EN
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (pop || !fifo_nonempty)                     wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(STARVE_LIMIT))    wait_cnt <= wait_cnt + 1'b1;
      stall_q <= (wait_cnt == WAIT_W'(STARVE_LIMIT)) && !pop;
    end
  end

  assign bus.stall_req = stall_q;
`else
  // Limit only matters when the wait counter is built; this folds to 0.
  assign bus.stall_req = (STARVE_LIMIT < 0);
`endif
endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register array between two writers: the pipeline writeback stage and the long-latency unit (multiply/divide, load-miss return).
- Writeback always wins. Long-latency results wait in a small FIFO and drain in idle write slots.
- Keeps a busy scoreboard of registers with outstanding long-latency writes, so decode can detect RAW hazards.
- Sits between WB/LU and the register array write inputs (enable, addr_w, data_w).

Parameters:
- DEPTH, 4: long-latency result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 8: cycles the FIFO head may wait before stall_req is raised.
- DATA_W, 32: write data width.
- ADDR_W, 5: register address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  pipeline writeback request
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result
- lu_addr  in  ADDR_W  result destination
- lu_data  in  DATA_W  result data
- iss_valid  in  1  long-latency op issued
- iss_addr  in  ADDR_W  destination of the issued op
- chk_addr_a  in  ADDR_W  decode source A
- chk_addr_b  in  ADDR_W  decode source B
- hazard_a  out  1  source A busy
- hazard_b  out  1  source B busy
- stall_req  out  1  request pipeline bubble
- rf_enable  out  1  register array write enable
- rf_addr_w  out  ADDR_W  register array write address
- rf_data_w  out  DATA_W  register array write data
- fifo_count  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Interface: single clock `clock`; reset `reset` is synchronous, active-high.
- Reset:
  - FIFO empty, busy vector all 0, wait counter 0.
  - stall_req=0, lu_ready=1, fifo_count=0.
  - rf_enable=0 while reset is high.
  - Reset mid-operation discards queued results and busy bits.
- Push: lu_ready = (count<DEPTH), derived from registers only.
  - Push on lu_valid && lu_ready; lu_valid while not ready is ignored (producer holds).
  - Minimum latency from push to register write is 1 cycle; there is no same-cycle bypass.
- Grant (combinational, each cycle):
  - wb_valid && wb_addr!=0 → rf_enable=1, write wb_addr/wb_data, no pop.
  - Else count>0 → pop FIFO head; rf_enable = (head.addr!=0); write head.addr/head.data.
  - Else rf_enable=0; rf_addr_w and rf_data_w = 0.
- Writes to $0: wb to $0 is not a request and frees the slot for the FIFO. A head entry to $0 is popped and discarded.
- Simultaneous push and pop: both occur; count unchanged. Push while full is impossible.
- Scoreboard:
  - iss_valid && iss_addr!=0 sets busy[iss_addr].
  - A FIFO pop clears busy[head.addr].
  - Set and clear of the same address in one cycle: set wins.
  - hazard_a = busy[chk_addr_a], hazard_b = busy[chk_addr_b], combinational. busy[0] is always 0.
- Starvation:
  - Wait counter increments each cycle count>0 with no pop; it clears on a pop or when count==0. It saturates at STARVE_LIMIT.
  - stall_req is registered: 1 from the cycle after the counter reaches STARVE_LIMIT until the cycle after the next pop.
  - Pipeline holds wb_valid=0 while stall_req=1. The arbiter does not rely on this for correctness.

Optional Feature:
- RF_ARB_STARVE_EN defined: wait counter and stall_req behave as above.
- Undefined: counter omitted, stall_req tied 0. The FIFO drains only in wb-idle slots, and lu_ready backpressure is the only flow control.

Decomposition:
- Package rf_arb_pkg: ADDR_W, DATA_W, ZERO_REG=0, and typedef rf_wr_entry_t {addr, data}.
- Sub-module rf_arb_fifo: circular buffer with push/pop/count, rd/wr pointers wrapping mod DEPTH, and head output.
- Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
- Reset held 2 cycles with lu_valid=1 → rf_enable=0, fifo_count=0, lu_ready=1, stall_req=0; no push is recorded.
- wb_valid=1 to $5 with 0xAAAA5555, with lu_valid=1 to $7 in the same cycle → rf write $5 this cycle. $7 is written the next cycle if wb is idle; busy[7] clears after that write.
- iss $9, then check chk_addr_a=9 → hazard_a=1. The lu result for $9 pops in cycle N → hazard_a=0 from cycle N+1. Issue of $9 in the same cycle as the pop → hazard stays 1.
- wb_valid=1 every cycle, 4 lu pushes → fifo_count=4, lu_ready=0. With RF_ARB_STARVE_EN, stall_req=1 after 8 waiting cycles; the first wb-idle cycle pops one entry, and stall_req drops the next cycle.
- wb to $0, FIFO head addressed to $3 → $3 is written that cycle. An lu result to $0 pops with rf_enable=0 and count decrements.
- 6 pushes and pops interleaved to exercise pointer wrap at DEPTH=4 → write order equals push order and the data matches.
